// File: rtl/alias_slice_bank_pkg.sv
// alias_slice_bank_pkg
//   Shared types and helpers for the aliased slice word bank.
//   - fsm_e     : bank state (INIT clear sweep, RUN normal operation)
//   - COLL_MAX  : saturation ceiling of the collision counter
//   - slice_lsb : bit position of slice s inside a word
package alias_slice_bank_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } fsm_e;

  localparam logic [15:0] COLL_MAX = 16'hFFFF;

  // Slice s occupies word bits [s*slice_w +: slice_w].
  function automatic int slice_lsb(input int s, input int slice_w);
    return s * slice_w;
  endfunction

endpackage

// File: rtl/alias_slice_arb.sv
// alias_slice_arb
//   Combinational fixed-priority resolver for concurrent slice writes.
//   Two or more valid channels aimed at the same (addr, slice) collide;
//   the lowest channel index wins.
//   Ports:
//     valid     [NCH]       per-channel write request
//     addr      [NCH*AW]    word index per channel
//     slice     [NCH*SW]    slice index per channel
//     grant     [NCH]       channel is valid and did not lose arbitration
//     collision             at least one channel lost this cycle
module alias_slice_arb
  import alias_slice_bank_pkg::*;
#(
  parameter int NCH = 2,
  parameter int AW  = 2,
  parameter int SW  = 1
) (
  input  logic [NCH-1:0]    valid,
  input  logic [NCH*AW-1:0] addr,
  input  logic [NCH*SW-1:0] slice,
  output logic [NCH-1:0]    grant,
  output logic              collision
);

  logic [NCH-1:0] lost;

  // A channel loses when any lower-indexed valid channel targets the same slot.
  always_comb begin
    lost = '0;
    for (int i = 1; i < NCH; i++) begin
      for (int j = 0; j < i; j++) begin
        if (valid[i] && valid[j] &&
            (addr[i*AW +: AW] == addr[j*AW +: AW]) &&
            (slice[i*SW +: SW] == slice[j*SW +: SW]))
          lost[i] = 1'b1;
      end
    end
  end

  assign grant     = valid & ~lost;
  assign collision = |lost;

endmodule

// File: rtl/alias_slice_bank.sv
// alias_slice_bank
//   DEPTH words of WIDTH bits, each also visible as NSLICE aliased slices of
//   SLICE_W bits. NCH channels write single slices; one read port returns a
//   full word or a zero-extended slice with one cycle of latency. A clear
//   sweep after reset zeroes every word before writes/reads are accepted.
//   Ports:
//     clk, rst_n          clock, synchronous active-low reset
//     init_done           clear sweep finished
//     wr_valid/wr_ready   per-channel write handshake (ready is combinational)
//     wr_addr/wr_slice/wr_data  packed per-channel write target and data
//     rd_valid, rd_full, rd_addr, rd_slice  read request
//     rd_data_valid, rd_data, rd_err        read result (rd_err: bad slice)
//     collision_cnt       saturating count of cycles with a write collision
//     err_range           sticky: write with slice index >= NSLICE seen
module alias_slice_bank
  import alias_slice_bank_pkg::*;
#(
  parameter  int WIDTH   = 32,
  parameter  int SLICE_W = 16,
  parameter  int DEPTH   = 4,
  parameter  int NCH     = 2,
  localparam int NSLICE  = WIDTH / SLICE_W,
  localparam int AW      = $clog2(DEPTH),
  localparam int SW      = (NSLICE > 1) ? $clog2(NSLICE) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 init_done,
  input  logic [NCH-1:0]       wr_valid,
  output logic [NCH-1:0]       wr_ready,
  input  logic [NCH*AW-1:0]    wr_addr,
  input  logic [NCH*SW-1:0]    wr_slice,
  input  logic [NCH*SLICE_W-1:0] wr_data,
  input  logic                 rd_valid,
  input  logic                 rd_full,
  input  logic [AW-1:0]        rd_addr,
  input  logic [SW-1:0]        rd_slice,
  output logic                 rd_data_valid,
  output logic [WIDTH-1:0]     rd_data,
  output logic                 rd_err,
  output logic [15:0]          collision_cnt,
  output logic                 err_range
);

  if (WIDTH % SLICE_W != 0) begin : g_bad_width
    $error("alias_slice_bank: WIDTH %0d is not a multiple of SLICE_W %0d", WIDTH, SLICE_W);
  end
  if (DEPTH < 2) begin : g_bad_depth
    $error("alias_slice_bank: DEPTH %0d must be at least 2", DEPTH);
  end
  if (NCH < 1) begin : g_bad_nch
    $error("alias_slice_bank: NCH %0d must be at least 1", NCH);
  end

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == COLL_MAX) ? c : c + 16'd1;
  endfunction

  fsm_e             state;
  logic [AW-1:0]    ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [NCH-1:0]   grant;
  logic             collision;
  logic             run;
  logic [NCH-1:0]   xfer;
  logic [NCH-1:0]   ch_ok;
  logic             bad_wr;
  logic [AW-1:0]    ch_addr  [NCH];
  logic [SW-1:0]    ch_slice [NCH];
  logic [WIDTH-1:0] rd_word_p0;
  logic [WIDTH-1:0] rd_view_p0;
  logic             rd_bad_p0;

  alias_slice_arb #(
    .NCH (NCH),
    .AW  (AW),
    .SW  (SW)
  ) u_arb (
    .valid     (wr_valid),
    .addr      (wr_addr),
    .slice     (wr_slice),
    .grant     (grant),
    .collision (collision)
  );

  assign run      = (state == RUN);
  // Idle channels stay ready; only arbitration losers are held off.
  assign wr_ready = run ? ~(wr_valid & ~grant) : '0;
  assign xfer     = wr_valid & wr_ready;

  // Out-of-range slices are accepted but never touch storage.
  always_comb begin
    bad_wr = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      ch_addr[i]  = wr_addr[i*AW +: AW];
      ch_slice[i] = wr_slice[i*SW +: SW];
      ch_ok[i]    = (int'(ch_slice[i]) < NSLICE) && (int'(ch_addr[i]) < DEPTH);
      if (xfer[i] && (int'(ch_slice[i]) >= NSLICE))
        bad_wr = 1'b1;
    end
  end

  // ---- stage p0: read select from pre-write storage ----
  always_comb begin
    rd_word_p0 = (int'(rd_addr) < DEPTH) ? mem[rd_addr] : '0;
    rd_view_p0 = '0;
    rd_bad_p0  = 1'b0;
    if (rd_full)
      rd_view_p0 = rd_word_p0;
    else if (int'(rd_slice) < NSLICE)
      rd_view_p0[SLICE_W-1:0] = rd_word_p0[slice_lsb(int'(rd_slice), SLICE_W) +: SLICE_W];
    else
      rd_bad_p0 = 1'b1;
  end

  // Storage: sweep clear during INIT, otherwise merge every accepted slice.
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      mem[ptr] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (xfer[i] && ch_ok[i])
          mem[ch_addr[i]][slice_lsb(int'(ch_slice[i]), SLICE_W) +: SLICE_W]
            <= wr_data[i*SLICE_W +: SLICE_W];
      end
    end
  end

  // ---- stage p1: registered control and read result ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= INIT;
      ptr           <= '0;
      init_done     <= 1'b0;
      rd_data_valid <= 1'b0;
      rd_err        <= 1'b0;
      rd_data       <= '0;
      collision_cnt <= '0;
      err_range     <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          if (int'(ptr) == DEPTH - 1) begin
            state     <= RUN;
            init_done <= 1'b1;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        RUN: begin
          if (collision)
            collision_cnt <= sat_inc(collision_cnt);
          if (bad_wr)
            err_range <= 1'b1;
        end
        default: state <= INIT;
      endcase
      rd_data_valid <= rd_valid && run;
      rd_err        <= rd_valid && run && rd_bad_p0;
      if (rd_valid && run)
        rd_data <= rd_view_p0;
    end
  end

endmodule

// File: tb/tb_alias_slice_bank.sv
module tb_alias_slice_bank;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance 0: defaults (WIDTH=32, SLICE_W=16, DEPTH=4, NCH=2 -> AW=2, SW=1)
  logic [1:0]  wv0, rdy0;
  logic [3:0]  wa0;
  logic [1:0]  ws0;
  logic [31:0] wd0;
  logic        rv0, rf0, rs0;
  logic [1:0]  ra0;
  logic        dv0, err0, er0, id0;
  logic [31:0] rd0;
  logic [15:0] cc0;

  // Instance 1: WIDTH=48 -> NSLICE=3, SW=2
  logic [1:0]  wv1, rdy1;
  logic [3:0]  wa1;
  logic [3:0]  ws1;
  logic [31:0] wd1;
  logic        rv1, rf1;
  logic [1:0]  ra1, rs1;
  logic        dv1, err1, er1, id1;
  logic [47:0] rd1;
  logic [15:0] cc1;

  alias_slice_bank u0 (
    .clk(clk), .rst_n(rst_n), .init_done(id0),
    .wr_valid(wv0), .wr_ready(rdy0), .wr_addr(wa0), .wr_slice(ws0), .wr_data(wd0),
    .rd_valid(rv0), .rd_full(rf0), .rd_addr(ra0), .rd_slice(rs0),
    .rd_data_valid(dv0), .rd_data(rd0), .rd_err(err0),
    .collision_cnt(cc0), .err_range(er0)
  );

  alias_slice_bank #(.WIDTH(48), .SLICE_W(16), .DEPTH(4), .NCH(2)) u1 (
    .clk(clk), .rst_n(rst_n), .init_done(id1),
    .wr_valid(wv1), .wr_ready(rdy1), .wr_addr(wa1), .wr_slice(ws1), .wr_data(wd1),
    .rd_valid(rv1), .rd_full(rf1), .rd_addr(ra1), .rd_slice(rs1),
    .rd_data_valid(dv1), .rd_data(rd1), .rd_err(err1),
    .collision_cnt(cc1), .err_range(er1)
  );

  int checks = 0;
  int errors = 0;

  // Reference model of instance 0
  logic [31:0] m0 [4];
  logic [15:0] cm0;
  logic [31:0] exp_rd0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs are already driven; checks ready, advances one edge, checks outputs.
  task automatic cyc0(input string tag);
    logic [1:0]  exp_rdy;
    logic [31:0] nm [4];
    logic        coll;
    logic        exp_dv;
    int          a, s;
    #1;
    coll = wv0[0] && wv0[1] && (wa0[1:0] == wa0[3:2]) && (ws0[0] == ws0[1]);
    exp_rdy = coll ? 2'b01 : 2'b11;
    chk({tag, " ready"}, 64'(rdy0), 64'(exp_rdy));
    nm = m0;
    for (int c = 0; c < 2; c++) begin
      if (wv0[c] && exp_rdy[c]) begin
        a = int'(wa0[c*2 +: 2]);
        s = int'(ws0[c]);
        nm[a] = (nm[a] & ~(32'hFFFF << (16 * s))) | (32'(wd0[c*16 +: 16]) << (16 * s));
      end
    end
    exp_dv = rv0;
    if (rv0)
      exp_rd0 = rf0 ? m0[ra0] : ((m0[ra0] >> (16 * int'(rs0))) & 32'hFFFF);
    if (coll && cm0 != 16'hFFFF)
      cm0 = cm0 + 16'd1;
    @(posedge clk); #1;
    m0 = nm;
    chk({tag, " rd_valid"}, 64'(dv0), 64'(exp_dv));
    chk({tag, " rd_data"}, 64'(rd0), 64'(exp_rd0));
    chk({tag, " rd_err"}, 64'(err0), 64'(1'b0));
    chk({tag, " coll_cnt"}, 64'(cc0), 64'(cm0));
  endtask

  task automatic wait_init(input string tag);
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!id0 && n < 20);
    chk({tag, " init_len"}, 64'(n), 64'd4);
    chk({tag, " init_done1"}, 64'(id1), 64'd1);
    chk({tag, " rd_ignored"}, 64'(dv0), 64'd0);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) m0[i] = '0;
    cm0 = '0;
    exp_rd0 = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    wv0 = 2'b11; wa0 = '0; ws0 = '0; wd0 = '0; rv0 = 1'b0; rf0 = 1'b0; ra0 = '0; rs0 = 1'b0;
    wv1 = '0; wa1 = '0; ws1 = '0; wd1 = '0; rv1 = 1'b0; rf1 = 1'b0; ra1 = '0; rs1 = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst ready", 64'(rdy0), 64'd0);
    chk("rst init_done", 64'(id0), 64'd0);
    chk("rst rd_valid", 64'(dv0), 64'd0);
    chk("rst rd_data", 64'(rd0), 64'd0);
    chk("rst coll_cnt", 64'(cc0), 64'd0);
    chk("rst err_range", 64'(er1), 64'd0);

    // Clear sweep; reads requested during it must be ignored
    rst_n = 1'b1; wv0 = '0; rv0 = 1'b1; rf0 = 1'b1;
    wait_init("init0");
    model_clear();

    for (int a = 0; a < 4; a++) begin
      rv0 = 1'b1; rf0 = 1'b1; ra0 = 2'(a);
      cyc0("idle_read");
      chk("idle_read zero", 64'(rd0), 64'd0);
    end

    // Slice merge into one word at the same edge
    rv0 = 1'b0;
    wv0 = 2'b11; wa0 = {2'd1, 2'd1}; ws0 = 2'b10; wd0 = {16'hDEAD, 16'hBEEF};
    cyc0("merge");
    wv0 = 2'b00; rv0 = 1'b1; rf0 = 1'b1; ra0 = 2'd1;
    cyc0("merge_full");
    chk("merge_full const", 64'(rd0), 64'h00000000DEADBEEF);
    rf0 = 1'b0; rs0 = 1'b1;
    cyc0("merge_slice1");
    chk("merge_slice1 const", 64'(rd0), 64'h000000000000DEAD);

    // Collision: ch0 wins, ch1 retries next cycle
    rv0 = 1'b0;
    wv0 = 2'b11; wa0 = {2'd2, 2'd2}; ws0 = 2'b00; wd0 = {16'h2222, 16'h1111};
    cyc0("coll");
    chk("coll ready const", 64'(rdy0), 64'd1);
    chk("coll cnt const", 64'(cc0), 64'd1);
    wv0 = 2'b10; rv0 = 1'b1; rf0 = 1'b1; ra0 = 2'd2;
    cyc0("coll_retry");
    chk("coll first word", 64'(rd0), 64'h0000000000001111);
    wv0 = 2'b00;
    cyc0("coll_after");
    chk("coll retry word", 64'(rd0), 64'h0000000000002222);

    // Read-during-write returns old data
    wv0 = 2'b01; wa0 = {2'd0, 2'd1}; ws0 = 2'b00; wd0 = 32'h0;
    rv0 = 1'b1; rf0 = 1'b1; ra0 = 2'd1;
    cyc0("rdw");
    chk("rdw old", 64'(rd0), 64'h00000000DEADBEEF);
    wv0 = 2'b00;
    cyc0("rdw_new");
    chk("rdw new", 64'(rd0), 64'h00000000DEAD0000);

    // Range error on the 3-slice instance
    wv1 = 2'b01; wa1 = 4'd0; ws1 = 4'd1; wd1 = 32'h0000ABCD;
    @(posedge clk); #1;
    chk("range pre err", 64'(er1), 64'd0);
    ws1 = 4'd3; wd1 = 32'h00005555;
    #1;
    chk("range ready", 64'(rdy1), 64'd3);
    @(posedge clk); #1;
    chk("range err set", 64'(er1), 64'd1);
    wv1 = 2'b00; rv1 = 1'b1; rf1 = 1'b1; ra1 = 2'd0;
    @(posedge clk); #1;
    chk("range full", 64'(rd1), 64'h00000000ABCD0000);
    chk("range full err", 64'(err1), 64'd0);
    rf1 = 1'b0; rs1 = 2'd3;
    @(posedge clk); #1;
    chk("range s3 valid", 64'(dv1), 64'd1);
    chk("range s3 err", 64'(err1), 64'd1);
    chk("range s3 data", 64'(rd1), 64'd0);
    rs1 = 2'd2;
    @(posedge clk); #1;
    chk("range s2 err", 64'(err1), 64'd0);
    chk("range s2 data", 64'(rd1), 64'd0);
    rs1 = 2'd1;
    @(posedge clk); #1;
    chk("range s1 data", 64'(rd1), 64'h000000000000ABCD);
    chk("range sticky", 64'(er1), 64'd1);
    rv1 = 1'b0;

    // Randomised traffic against the model
    for (int k = 0; k < 400; k++) begin
      wv0 = 2'($urandom_range(0, 3));
      wa0 = {2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      ws0 = 2'($urandom_range(0, 3));
      wd0 = $urandom;
      rv0 = 1'($urandom_range(0, 1));
      rf0 = 1'($urandom_range(0, 1));
      ra0 = 2'($urandom_range(0, 3));
      rs0 = 1'($urandom_range(0, 1));
      cyc0("rand");
    end

    // Reset in the cycle after a read
    wv0 = 2'b00; rv0 = 1'b1; rf0 = 1'b1; ra0 = 2'd1;
    cyc0("pre_reset");
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst rd_valid", 64'(dv0), 64'd0);
    chk("midrst rd_data", 64'(rd0), 64'd0);
    chk("midrst coll_cnt", 64'(cc0), 64'd0);
    chk("midrst err_range", 64'(er1), 64'd0);
    chk("midrst init_done", 64'(id0), 64'd0);
    rst_n = 1'b1; rv0 = 1'b0;
    wait_init("init1");
    model_clear();
    for (int a = 0; a < 4; a++) begin
      rv0 = 1'b1; rf0 = 1'b1; ra0 = 2'(a);
      cyc0("reclear_read");
      chk("reclear zero", 64'(rd0), 64'd0);
    end
    rv1 = 1'b1; rf1 = 1'b1; ra1 = 2'd0;
    @(posedge clk); #1;
    chk("reclear u1", 64'(rd1), 64'd0);
    rv1 = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
